// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master sequencer: FSM encoding and default
// word width / SCLK half-period settings.
package spi_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  // Half-period in system clocks for each div_sel setting
  localparam int DEF_HALF_0 = 5;
  localparam int DEF_HALF_1 = 10;
  localparam int DEF_HALF_2 = 20;
  localparam int DEF_HALF_3 = 50;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_LOAD     = 3'd3;
  localparam logic [2:0] ST_CS_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    CS_SETUP = ST_CS_SETUP,
    SHIFT    = ST_SHIFT,
    LOAD     = ST_LOAD,
    CS_HOLD  = ST_CS_HOLD
  } spi_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one-cycle registered tick every HALF_sel clocks
// while enabled; held at zero when disabled or cleared.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int HALF_0 = DEF_HALF_0,
  parameter int HALF_1 = DEF_HALF_1,
  parameter int HALF_2 = DEF_HALF_2,
  parameter int HALF_3 = DEF_HALF_3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] sel,
  output logic       tick_o
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_m1;

  always_comb begin
    half_m1 = CNT_W'(HALF_0 - 1);
    case (sel)
      2'd0:    half_m1 = CNT_W'(HALF_0 - 1);
      2'd1:    half_m1 = CNT_W'(HALF_1 - 1);
      2'd2:    half_m1 = CNT_W'(HALF_2 - 1);
      default: half_m1 = CNT_W'(HALF_3 - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else if (clr || !en) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else if (cnt == half_m1) begin
      cnt    <= '0;
      tick_o <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_master_seq.sv
// SPI mode-0 (CPOL=0, CPHA=0) MSB-first burst master, 1..16 words per burst.
// Build option SPI_LOOPBACK_EN: receive path samples mosi_o instead of miso_i.
//
// Handshake: start_i is a level sampled only in IDLE; data_req_o is high for
// exactly the LOAD cycle and data_i is captured on the clock edge ending it.
module spi_master_seq
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int HALF_0 = DEF_HALF_0,
  parameter int HALF_1 = DEF_HALF_1,
  parameter int HALF_2 = DEF_HALF_2,
  parameter int HALF_3 = DEF_HALF_3
) (
  input  logic              clk_10Mhz_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [3:0]        n_words_i,
  input  logic [1:0]        div_sel_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              data_req_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o
);

  // Each word is 2*DATA_W half-period ticks; the last one is a falling edge
  localparam logic [3:0] LAST_TICK = 4'(2 * DATA_W - 1);

  spi_state_t        state;
  logic [1:0]        div_q;
  logic [3:0]        words_left;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              tick;
  logic              tick_en;
  logic              tick_clr;
  logic              rx_bit;

  assign tick_en    = (state != IDLE);
  assign tick_clr   = ((state == IDLE) && start_i) || (state == LOAD);
  assign data_req_o = (state == LOAD);

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = mosi_o;
`else
  assign rx_bit = miso_i;
`endif

  spi_tick_gen #(
    .CNT_W  (CNT_W),
    .HALF_0 (HALF_0),
    .HALF_1 (HALF_1),
    .HALF_2 (HALF_2),
    .HALF_3 (HALF_3)
  ) u_tick (
    .clk    (clk_10Mhz_i),
    .rst_n  (rst_n_i),
    .en     (tick_en),
    .clr    (tick_clr),
    .sel    (div_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk_10Mhz_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      div_q      <= 2'd0;
      words_left <= 4'd0;
      bit_cnt    <= 4'd0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      sclk_o     <= 1'b0;
      mosi_o     <= 1'b0;
      cs_n_o     <= 1'b1;
    end else begin
      rx_valid_o <= 1'b0;
      done_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            div_q      <= div_sel_i;
            words_left <= n_words_i;
            tx_sr      <= data_i;
            mosi_o     <= data_i[DATA_W-1];
            cs_n_o     <= 1'b0;
            busy_o     <= 1'b1;
            state      <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (tick) begin
            bit_cnt <= 4'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (!bit_cnt[0]) begin
              sclk_o <= 1'b1;
              rx_sr  <= {rx_sr[DATA_W-2:0], rx_bit};
            end else begin
              sclk_o <= 1'b0;
              tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
              mosi_o <= tx_sr[DATA_W-2];
              if (bit_cnt == LAST_TICK) begin
                rx_data_o  <= rx_sr;
                rx_valid_o <= 1'b1;
                state      <= (words_left != 4'd0) ? LOAD : CS_HOLD;
              end
            end
          end
        end
        LOAD: begin
          tx_sr      <= data_i;
          mosi_o     <= data_i[DATA_W-1];
          words_left <= words_left - 4'd1;
          bit_cnt    <= 4'd0;
          state      <= SHIFT;
        end
        CS_HOLD: begin
          if (tick) begin
            cs_n_o <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
SPI master transfer sequencer, mode 0 (CPOL=0, CPHA=0), MSB first.
- Contains its own selectable half-period tick generator.
- Drives SCLK, MOSI and CS_n for bursts of 1..16 bytes requested by a host-side controller.
- Sits between the top-level control logic (switches/FSM) and the off-chip SPI peripheral pins.

Parameters:
DATA_W, 8, bits per SPI word
CNT_W, 16, width of the half-period tick counter
HALF_0, 5, half-period in clk cycles for div_sel_i=0
HALF_1, 10, half-period for div_sel_i=1
HALF_2, 20, half-period for div_sel_i=2
HALF_3, 50, half-period for div_sel_i=3

Ports:
clk_10Mhz_i  in  1  system clock, 10 MHz
rst_n_i  in  1  synchronous, active-low reset
start_i  in  1  start burst; sampled only in IDLE
n_words_i  in  4  burst length minus 1 (0 = 1 word, 15 = 16 words)
div_sel_i  in  2  SCLK rate select; latched at start
data_i  in  DATA_W  TX word; must be valid while data_req_o=1 and at start
data_req_o  out  1  one-cycle pulse; data_i sampled on this edge
rx_data_o  out  DATA_W  last received word
rx_valid_o  out  1  one-cycle pulse when rx_data_o updates
busy_o  out  1  high from start acceptance until burst end
done_o  out  1  one-cycle pulse at burst end
sclk_o  out  1  SPI clock; idles low
mosi_o  out  1  SPI data out
miso_i  in  1  SPI data in
cs_n_o  out  1  chip select, active low; idles high

Behaviour:
- Reset (rst_n_i=0 at a clock edge) values: sclk_o=0, cs_n_o=1, mosi_o=0, busy_o=0, done_o=0, data_req_o=0, rx_valid_o=0, rx_data_o=0; FSM goes to IDLE and tick counter clears. Reset mid-burst aborts immediately, with no done_o.
- Tick generator:
  - Counter runs only when the FSM is not IDLE.
  - tick=1 for one cycle when counter reaches HALF_sel-1; counter then wraps to 0.
  - Counter is cleared when entering CS_SETUP.
- FSM states: IDLE, CS_SETUP, SHIFT, LOAD, CS_HOLD.
- IDLE:
  - On start_i=1: latch div_sel_i and n_words_i, load shift_reg<=data_i, drive mosi_o<=data_i[MSB], set cs_n_o<=0 and busy_o<=1, go to CS_SETUP.
  - start_i is ignored in all other states.
- CS_SETUP: wait 1 tick, then go to SHIFT with bit_cnt=0.
- SHIFT (each tick toggles sclk_o):
  - Rising edge (sclk 0->1): sample miso_i into rx shift LSB.
  - Falling edge: shift TX and present the next bit on mosi_o.
  - After the 8th falling edge (16 ticks): rx_data_o<=rx shift and rx_valid_o pulse. Then go to LOAD if words_left>0, otherwise to CS_HOLD.
- LOAD:
  - data_req_o=1 for exactly one cycle; shift_reg<=data_i, mosi_o<=data_i[MSB], words_left decrements.
  - Returns to SHIFT with the tick counter cleared.
  - cs_n_o stays low between words.
- CS_HOLD: wait 1 tick with sclk_o=0, then cs_n_o<=1, busy_o<=0, done_o pulse, go to IDLE.
- Latency for 1 word, half-period H: start edge to done_o = 18*H + 1 cycles.
- A new start_i is accepted on the cycle after done_o.
- Width rules:
  - words_left is 4-bit; no wrap, since it stops at 0.
  - bit_cnt is 4-bit, counting ticks 0..15.

Optional Feature:
SPI_LOOPBACK_EN
- When defined: the received bit is taken from internal mosi_o instead of miso_i, so rx_data_o equals the transmitted word; the miso_i port remains but is unused.
- When undefined: normal sampling of miso_i.

Decomposition:
Shared package spi_pkg contains:
- state enum spi_state_t {IDLE, CS_SETUP, SHIFT, LOAD, CS_HOLD};
- DATA_W;
- default HALF_n constants.

Sub-module spi_tick_gen:
- Ports: clk, rst_n, en, clr, sel[1:0], tick_o.
- Parameterised by HALF_0..3.
- Natural to split out.

Test Plan:
- Reset then idle: rst_n_i=0 for 3 cycles, then 1 -> cs_n_o=1, sclk_o=0, busy_o=0 held for 100 cycles with start_i=0.
- Single word: div_sel=0, n_words=0, data_i=8'hA5, miso pattern 8'h3C -> mosi shows 1,0,1,0,0,1,0,1 on rising edges; rx_data_o=8'h3C with rx_valid pulse; done_o exactly 91 cycles after start.
- Burst: n_words=2, data 8'h01/8'h80/8'hFF supplied on data_req_o -> exactly 2 data_req_o pulses, cs_n_o low continuously for 3 words, 3 rx_valid pulses, 1 done_o.
- Rate select: div_sel=3 -> sclk_o high and low each 50 cycles; change div_sel_i mid-burst -> no effect until the next start.
- Reset mid-operation: rst_n_i=0 at the 5th SCLK rising edge -> next cycle cs_n_o=1, sclk_o=0, busy_o=0, no done_o; a new start works normally.
- Loopback (SPI_LOOPBACK_EN defined): data_i=8'h5A, miso_i tied 0 -> rx_data_o=8'h5A.
